// File: rtl/lnrv_exu_flush_ctrl.sv
// EXU flush controller: trap/branch flush arbitration, redirect PC
// register and IFU redirect handshake with a saturating flush counter.
module lnrv_exu_flush_ctrl #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 brch_flush_req,
  output logic                 brch_flush_ack,
  input  logic [31:0]          brch_flush_pc_op1,
  input  logic [31:0]          brch_flush_pc_op2,
  input  logic                 trap_flush_req,
  output logic                 trap_flush_ack,
  input  logic [31:0]          trap_flush_pc,
  output logic                 ifu_flush_req,
  input  logic                 ifu_flush_rdy,
  output logic [31:0]          ifu_flush_pc,
  output logic                 flush_busy,
  output logic [CNT_WIDTH-1:0] flush_cnt
);

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [31:0]          pc_q, pc_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  logic        xfer;
  logic        can_accept;
  logic [31:0] brch_sum;
  logic [31:0] brch_tgt;
  logic [31:0] trap_tgt;

  always_comb begin
    xfer       = (state_q == PEND) & ifu_flush_rdy;
    can_accept = (state_q == IDLE) | xfer;
    brch_sum   = brch_flush_pc_op1 + brch_flush_pc_op2;
    brch_tgt   = {brch_sum[31:1], 1'b0};
    trap_tgt   = {trap_flush_pc[31:1], 1'b0};

    // trap wins; a stalled IFU blocks both sources
    trap_flush_ack = trap_flush_req & can_accept;
    brch_flush_ack = brch_flush_req & ~trap_flush_req & can_accept;

    state_d = state_q;
    pc_d    = pc_q;
    if (trap_flush_ack) begin
      state_d = PEND;
      pc_d    = trap_tgt;
    end else if (brch_flush_ack) begin
      state_d = PEND;
      pc_d    = brch_tgt;
    end else if (xfer) begin
      state_d = IDLE;
    end

    cnt_d = cnt_q;
    if (xfer && (cnt_q != {CNT_WIDTH{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ifu_flush_req = (state_q == PEND);
  assign ifu_flush_pc  = pc_q;
  assign flush_busy    = (state_q == PEND);
  assign flush_cnt     = cnt_q;

endmodule

// File: tb/tb_lnrv_exu_flush_ctrl.sv
// Directed bench for lnrv_exu_flush_ctrl (CNT_WIDTH = 4 so the
// counter saturates quickly).
module tb_lnrv_exu_flush_ctrl;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          brch_flush_req = 1'b0;
  logic          brch_flush_ack;
  logic [31:0]   brch_flush_pc_op1 = '0;
  logic [31:0]   brch_flush_pc_op2 = '0;
  logic          trap_flush_req = 1'b0;
  logic          trap_flush_ack;
  logic [31:0]   trap_flush_pc = '0;
  logic          ifu_flush_req;
  logic          ifu_flush_rdy = 1'b0;
  logic [31:0]   ifu_flush_pc;
  logic          flush_busy;
  logic [CW-1:0] flush_cnt;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  lnrv_exu_flush_ctrl #(.CNT_WIDTH(CW)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .brch_flush_req    (brch_flush_req),
    .brch_flush_ack    (brch_flush_ack),
    .brch_flush_pc_op1 (brch_flush_pc_op1),
    .brch_flush_pc_op2 (brch_flush_pc_op2),
    .trap_flush_req    (trap_flush_req),
    .trap_flush_ack    (trap_flush_ack),
    .trap_flush_pc     (trap_flush_pc),
    .ifu_flush_req     (ifu_flush_req),
    .ifu_flush_rdy     (ifu_flush_rdy),
    .ifu_flush_pc      (ifu_flush_pc),
    .flush_busy        (flush_busy),
    .flush_cnt         (flush_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h exp 0x%08h", tag, got, exp);
    end
  endtask

  // advance one rising edge, then settle away from it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset
    #2 rst_n = 1'b0;
    #1;
    chk("rst_req", ifu_flush_req, 0);
    chk("rst_busy", flush_busy, 0);
    chk("rst_pc", ifu_flush_pc, 0);
    chk("rst_cnt", flush_cnt, 0);
    chk("rst_back", brch_flush_ack, 0);
    chk("rst_tack", trap_flush_ack, 0);
    #20 rst_n = 1'b1;
    tick();

    // single branch redirect
    brch_flush_req = 1'b1;
    brch_flush_pc_op1 = 32'h8000_0100;
    brch_flush_pc_op2 = 32'hFFFF_FFF0;
    ifu_flush_rdy = 1'b1;
    #1;
    chk("b1_back", brch_flush_ack, 1);
    chk("b1_tack", trap_flush_ack, 0);
    tick();
    brch_flush_req = 1'b0;
    chk("b1_req", ifu_flush_req, 1);
    chk("b1_busy", flush_busy, 1);
    chk("b1_pc", ifu_flush_pc, 32'h8000_00F0);
    chk("b1_cnt0", flush_cnt, 0);
    tick();
    chk("b1_idle", ifu_flush_req, 0);
    chk("b1_cnt", flush_cnt, 1);

    // JALR bit-0 clear with wrap
    brch_flush_req = 1'b1;
    brch_flush_pc_op1 = 32'hFFFF_FFFF;
    brch_flush_pc_op2 = 32'h0000_0006;
    #1;
    chk("b2_back", brch_flush_ack, 1);
    tick();
    brch_flush_req = 1'b0;
    chk("b2_pc", ifu_flush_pc, 32'h0000_0004);
    tick();
    chk("b2_cnt", flush_cnt, 2);

    // IFU backpressure, trap arrives during stall
    ifu_flush_rdy = 1'b0;
    brch_flush_req = 1'b1;
    brch_flush_pc_op1 = 32'h0000_0100;
    brch_flush_pc_op2 = 32'h0;
    #1;
    chk("bp_back", brch_flush_ack, 1);
    tick();
    brch_flush_req = 1'b0;
    trap_flush_req = 1'b1;
    trap_flush_pc = 32'h0000_0200;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_tack0", trap_flush_ack, 0);
      chk("bp_back0", brch_flush_ack, 0);
      chk("bp_pc", ifu_flush_pc, 32'h0000_0100);
      chk("bp_req", ifu_flush_req, 1);
      tick();
    end
    chk("bp_cnt_hold", flush_cnt, 2);
    ifu_flush_rdy = 1'b1;
    #1;
    chk("bp_tack", trap_flush_ack, 1);
    tick();
    trap_flush_req = 1'b0;
    chk("bp_pc2", ifu_flush_pc, 32'h0000_0200);
    chk("bp_nobub", ifu_flush_req, 1);
    chk("bp_cnt3", flush_cnt, 3);
    tick();
    chk("bp_idle", ifu_flush_req, 0);
    chk("bp_cnt4", flush_cnt, 4);

    // simultaneous trap and branch in IDLE
    trap_flush_req = 1'b1;
    trap_flush_pc = 32'h0000_0040;
    brch_flush_req = 1'b1;
    brch_flush_pc_op1 = 32'h0000_0200;
    brch_flush_pc_op2 = 32'h0000_0100;
    #1;
    chk("sim_tack", trap_flush_ack, 1);
    chk("sim_back0", brch_flush_ack, 0);
    tick();
    trap_flush_req = 1'b0;
    #1;
    chk("sim_pc1", ifu_flush_pc, 32'h0000_0040);
    chk("sim_back1", brch_flush_ack, 1);
    chk("sim_tack1", trap_flush_ack, 0);
    tick();
    brch_flush_req = 1'b0;
    chk("sim_pc2", ifu_flush_pc, 32'h0000_0300);
    chk("sim_req", ifu_flush_req, 1);
    chk("sim_cnt5", flush_cnt, 5);
    tick();
    chk("sim_cnt6", flush_cnt, 6);

    // counter saturation: fresh reset, 17 redirects, then one more
    #2 rst_n = 1'b0;
    #1;
    chk("sat_rst", flush_cnt, 0);
    #10 rst_n = 1'b1;
    tick();
    for (int i = 0; i < 18; i++) begin
      trap_flush_req = 1'b1;
      trap_flush_pc = 32'(i * 4);
      tick();
      trap_flush_req = 1'b0;
      tick();
      if (i == 13) chk("sat_14", flush_cnt, 14);
      if (i == 14) chk("sat_15", flush_cnt, 15);
      if (i == 16) chk("sat_17", flush_cnt, 15);
      if (i == 17) chk("sat_hold", flush_cnt, 15);
    end

    // reset while a redirect is stalled
    ifu_flush_rdy = 1'b0;
    brch_flush_req = 1'b1;
    brch_flush_pc_op1 = 32'h0000_0500;
    brch_flush_pc_op2 = 32'h0;
    tick();
    brch_flush_req = 1'b0;
    chk("mr_req1", ifu_flush_req, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_req0", ifu_flush_req, 0);
    chk("mr_busy0", flush_busy, 0);
    chk("mr_cnt0", flush_cnt, 0);
    chk("mr_pc0", ifu_flush_pc, 0);
    #10 rst_n = 1'b1;
    ifu_flush_rdy = 1'b1;
    tick();
    chk("mr_quiet1", ifu_flush_req, 0);
    tick();
    chk("mr_quiet2", ifu_flush_req, 0);
    chk("mr_cnt", flush_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
